// File: rtl/shared_vc_bank_client.sv
// Per-input-port shared-VC client: allocates VCs of owned memory banks round-robin and tracks the allocated mask.
// Optional SHARED_VC_STATS_EN adds saturating grant/nack counters (stat_grants, stat_nacks).
module shared_vc_bank_client #(
    parameter int num_ports  = 5,
    parameter int num_vcs    = 10,
    parameter int port_id    = 0,
    parameter int stat_width = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [num_ports*num_ports-1:0] memory_bank_grant_in,
    input  logic [num_ports-1:0]         ready_for_allocation,
    input  logic                         alloc_req,
    output logic                         alloc_gnt,
    output logic                         alloc_nack,
    output logic [$clog2(num_vcs)-1:0]   alloc_vc,
    input  logic                         release_valid,
    input  logic [$clog2(num_vcs)-1:0]   release_vc,
    output logic [num_vcs-1:0]           allocated_ip_shared_ivc,
    output logic [num_ports-1:0]         bank_draining,
`ifdef SHARED_VC_STATS_EN
    output logic [stat_width-1:0]        stat_grants,
    output logic [stat_width-1:0]        stat_nacks,
`endif
    output logic                         release_error
);

    localparam int VPB   = num_vcs / num_ports;
    localparam int VC_W  = $clog2(num_vcs);
    localparam int PTR_W = $clog2(num_ports);

    typedef enum logic [0:0] {IDLE = 1'b0, DECIDE = 1'b1} state_t;

    state_t             state_r, state_next_s;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [num_ports-1:0] owned_s, eligible_s, draining_next_s;
    logic [num_vcs-1:0] rel_mask_s, set_mask_s, mask_next_s;
    logic               decide_s, found_s, rel_hit_s;
    logic [PTR_W-1:0]   found_bank_s;
    logic [VC_W-1:0]    found_vc_s;

    // Ownership and eligibility per bank from the allocators' grant vectors
    always_comb begin
        for (int b = 0; b < num_ports; b++) begin
            owned_s[b]    = memory_bank_grant_in[b*num_ports+port_id];
            eligible_s[b] = owned_s[b] & ready_for_allocation[b];
        end
    end

    // Allocation FSM next state; DECIDE lasts exactly one cycle
    always_comb begin
        state_next_s = state_r;
        decide_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (alloc_req) begin
                    state_next_s = DECIDE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DECIDE: begin
                state_next_s = IDLE;
                decide_s     = 1'b1;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Round-robin bank search from rr_ptr over the pre-release mask, lowest free slot first
    always_comb begin
        found_s      = 1'b0;
        found_bank_s = {PTR_W{1'b0}};
        found_vc_s   = {VC_W{1'b0}};
        for (int i = 0; i < num_ports; i++) begin
            for (int s = 0; s < VPB; s++) begin
                if (!found_s && eligible_s[(int'(rr_ptr_r) + i) % num_ports] &&
                    !mask_r_bit((int'(rr_ptr_r) + i) % num_ports, s)) begin
                    found_s      = 1'b1;
                    found_bank_s = PTR_W'((int'(rr_ptr_r) + i) % num_ports);
                    found_vc_s   = VC_W'(((int'(rr_ptr_r) + i) % num_ports) * VPB + s);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    function automatic logic mask_r_bit(input int bank, input int slot);
        return allocated_ip_shared_ivc[bank*VPB+slot];
    endfunction

    // Mask update: release clears its bit, a grant sets the chosen bit
    always_comb begin
        for (int v = 0; v < num_vcs; v++) begin
            rel_mask_s[v] = release_valid & (release_vc == VC_W'(v));
            set_mask_s[v] = decide_s & found_s & (found_vc_s == VC_W'(v));
        end
        rel_hit_s   = |(rel_mask_s & allocated_ip_shared_ivc);
        mask_next_s = (allocated_ip_shared_ivc & ~rel_mask_s) | set_mask_s;
        for (int b = 0; b < num_ports; b++) begin
            draining_next_s[b] = ~owned_s[b] & (|mask_next_s[b*VPB +: VPB]);
        end
    end

    // State, mask and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r                 <= IDLE;
            rr_ptr_r                <= {PTR_W{1'b0}};
            allocated_ip_shared_ivc <= {num_vcs{1'b0}};
            bank_draining           <= {num_ports{1'b0}};
            alloc_gnt               <= 1'b0;
            alloc_nack              <= 1'b0;
            alloc_vc                <= {VC_W{1'b0}};
            release_error           <= 1'b0;
        end else begin
            state_r                 <= state_next_s;
            allocated_ip_shared_ivc <= mask_next_s;
            bank_draining           <= draining_next_s;
            alloc_gnt               <= decide_s & found_s;
            alloc_nack              <= decide_s & ~found_s;
            if (decide_s && found_s) begin
                alloc_vc <= found_vc_s;
                rr_ptr_r <= (found_bank_s == PTR_W'(num_ports-1)) ? {PTR_W{1'b0}}
                                                                  : found_bank_s + PTR_W'(1);
            end else begin
                alloc_vc <= alloc_vc;
                rr_ptr_r <= rr_ptr_r;
            end
            if (release_valid && !rel_hit_s) begin
                release_error <= 1'b1;
            end else begin
                release_error <= release_error;
            end
        end
    end

`ifdef SHARED_VC_STATS_EN
    // Saturating grant/nack counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants <= {stat_width{1'b0}};
            stat_nacks  <= {stat_width{1'b0}};
        end else begin
            if (decide_s && found_s && stat_grants != {stat_width{1'b1}}) begin
                stat_grants <= stat_grants + stat_width'(1);
            end else begin
                stat_grants <= stat_grants;
            end
            if (decide_s && !found_s && stat_nacks != {stat_width{1'b1}}) begin
                stat_nacks <= stat_nacks + stat_width'(1);
            end else begin
                stat_nacks <= stat_nacks;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shared_vc_bank_client.sv
// Directed self-checking bench for shared_vc_bank_client (num_ports=5, num_vcs=10, port_id=0).
module tb_shared_vc_bank_client;

    logic        clk;
    logic        reset;
    logic [24:0] memory_bank_grant_in;
    logic [4:0]  ready_for_allocation;
    logic        alloc_req;
    logic        alloc_gnt;
    logic        alloc_nack;
    logic [3:0]  alloc_vc;
    logic        release_valid;
    logic [3:0]  release_vc;
    logic [9:0]  allocated_ip_shared_ivc;
    logic [4:0]  bank_draining;
    logic        release_error;
`ifdef SHARED_VC_STATS_EN
    logic [7:0]  stat_grants;
    logic [7:0]  stat_nacks;
`endif

    int checks = 0;
    int errors = 0;

    shared_vc_bank_client #(.num_ports(5), .num_vcs(10), .port_id(0), .stat_width(8)) dut (
        .clk(clk),
        .reset(reset),
        .memory_bank_grant_in(memory_bank_grant_in),
        .ready_for_allocation(ready_for_allocation),
        .alloc_req(alloc_req),
        .alloc_gnt(alloc_gnt),
        .alloc_nack(alloc_nack),
        .alloc_vc(alloc_vc),
        .release_valid(release_valid),
        .release_vc(release_vc),
        .allocated_ip_shared_ivc(allocated_ip_shared_ivc),
        .bank_draining(bank_draining),
`ifdef SHARED_VC_STATS_EN
        .stat_grants(stat_grants),
        .stat_nacks(stat_nacks),
`endif
        .release_error(release_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_own(input logic [4:0] own);
        @(negedge clk);
        memory_bank_grant_in = 25'd0;
        for (int b = 0; b < 5; b++) memory_bank_grant_in[b*5] = own[b];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        alloc_req = 1'b0;
        release_valid = 1'b0;
        release_vc = 4'd0;
        memory_bank_grant_in = 25'd0;
        ready_for_allocation = 5'b11111;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One request; returns outputs sampled in the gnt/nack cycle
    task automatic do_req(output logic g, output logic n, output logic [3:0] v);
        @(negedge clk);
        alloc_req = 1'b1;
        @(negedge clk);
        alloc_req = 1'b0;
        @(negedge clk);
        g = alloc_gnt;
        n = alloc_nack;
        v = alloc_vc;
    endtask

    task automatic do_release(input logic [3:0] vc);
        @(negedge clk);
        release_valid = 1'b1;
        release_vc = vc;
        @(negedge clk);
        release_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic g, n;
        logic [3:0] v;
        do_reset();
        checks++;
        if ({alloc_gnt, alloc_nack, alloc_vc, allocated_ip_shared_ivc, bank_draining, release_error} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b nack=%b vc=%0d mask=%b drain=%b err=%b, want all 0",
                     alloc_gnt, alloc_nack, alloc_vc, allocated_ip_shared_ivc, bank_draining, release_error);
        end
        // Latency: nothing visible in the DECIDE cycle, nack one cycle later
        @(negedge clk);
        alloc_req = 1'b1;
        @(negedge clk);
        alloc_req = 1'b0;
        checks++;
        if ({alloc_gnt, alloc_nack} !== 2'b00) begin
            errors++;
            $display("FAIL early_response: got gnt/nack=%b%b, want 00", alloc_gnt, alloc_nack);
        end
        @(negedge clk);
        checks++;
        if ({alloc_gnt, alloc_nack, allocated_ip_shared_ivc} !== {2'b01, 10'd0}) begin
            errors++;
            $display("FAIL no_grant_nack: got gnt=%b nack=%b mask=%b, want gnt=0 nack=1 mask=0",
                     alloc_gnt, alloc_nack, allocated_ip_shared_ivc);
        end
        @(negedge clk);
        checks++;
        if (alloc_nack !== 1'b0) begin
            errors++;
            $display("FAIL nack_pulse: got nack=%b one cycle later, want 0", alloc_nack);
        end
        do_req(g, n, v);
    endtask

    task automatic test_single_grant();
        logic g, n;
        logic [3:0] v;
        do_reset();
        set_own(5'b00100);
        do_req(g, n, v);
        checks++;
        if ({g, n, v, allocated_ip_shared_ivc} !== {2'b10, 4'd4, 10'b00000_10000}) begin
            errors++;
            $display("FAIL bank2_grant: got gnt=%b nack=%b vc=%0d mask=%b, want gnt=1 vc=4 mask=0000010000",
                     g, n, v, allocated_ip_shared_ivc);
        end
    endtask

    task automatic test_round_robin();
        logic g, n;
        logic [3:0] v;
        logic [3:0] exp_vc [4] = '{4'd0, 4'd6, 4'd1, 4'd7};
        do_reset();
        set_own(5'b01001);
        for (int i = 0; i < 4; i++) begin
            do_req(g, n, v);
            checks++;
            if ({g, n, v} !== {2'b10, exp_vc[i]}) begin
                errors++;
                $display("FAIL rr_grant%0d: got gnt=%b nack=%b vc=%0d, want gnt=1 vc=%0d", i, g, n, v, exp_vc[i]);
            end
        end
        do_req(g, n, v);
        checks++;
        if ({g, n, v, allocated_ip_shared_ivc} !== {2'b01, 4'd7, 10'b00110_00011}) begin
            errors++;
            $display("FAIL rr_full_nack: got gnt=%b nack=%b vc=%0d mask=%b, want nack=1 vc=7 mask=0011000011",
                     g, n, v, allocated_ip_shared_ivc);
        end
        // rr_ptr sits at 4: bank 4 first, then pointer wraps to 0 and finds bank 1
        set_own(5'b10010);
        do_req(g, n, v);
        checks++;
        if ({g, v} !== {1'b1, 4'd8}) begin
            errors++;
            $display("FAIL rr_bank4: got gnt=%b vc=%0d, want gnt=1 vc=8", g, v);
        end
        do_req(g, n, v);
        checks++;
        if ({g, v} !== {1'b1, 4'd2}) begin
            errors++;
            $display("FAIL rr_wrap: got gnt=%b vc=%0d, want gnt=1 vc=2", g, v);
        end
        checks++;
        if (bank_draining !== 5'b01001) begin
            errors++;
            $display("FAIL rr_draining: got %b, want 01001", bank_draining);
        end
    endtask

    task automatic test_draining();
        logic g, n;
        logic [3:0] v;
        do_reset();
        set_own(5'b00010);
        do_req(g, n, v);
        checks++;
        if ({g, v} !== {1'b1, 4'd2}) begin
            errors++;
            $display("FAIL drain_alloc: got gnt=%b vc=%0d, want gnt=1 vc=2", g, v);
        end
        set_own(5'b00000);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bank_draining !== 5'b00010) begin
            errors++;
            $display("FAIL draining_set: got %b, want 00010", bank_draining);
        end
        do_req(g, n, v);
        checks++;
        if ({g, n} !== 2'b01) begin
            errors++;
            $display("FAIL drain_no_alloc: got gnt=%b nack=%b, want nack", g, n);
        end
        do_release(4'd2);
        checks++;
        if ({bank_draining, allocated_ip_shared_ivc, release_error} !== 16'd0) begin
            errors++;
            $display("FAIL draining_clear: got drain=%b mask=%b err=%b, want all 0",
                     bank_draining, allocated_ip_shared_ivc, release_error);
        end
        // Regained ownership but not ready: still refused; then ready -> granted
        @(negedge clk);
        ready_for_allocation = 5'b11101;
        set_own(5'b00010);
        do_req(g, n, v);
        checks++;
        if ({g, n} !== 2'b01) begin
            errors++;
            $display("FAIL regain_not_ready: got gnt=%b nack=%b, want nack", g, n);
        end
        @(negedge clk);
        ready_for_allocation = 5'b11111;
        do_req(g, n, v);
        checks++;
        if ({g, v} !== {1'b1, 4'd2}) begin
            errors++;
            $display("FAIL regain_grant: got gnt=%b vc=%0d, want gnt=1 vc=2", g, v);
        end
    endtask

    task automatic test_release_error();
        do_release(4'd5);
        checks++;
        if ({release_error, allocated_ip_shared_ivc} !== {1'b1, 10'b00000_00100}) begin
            errors++;
            $display("FAIL release_error_set: got err=%b mask=%b, want err=1 mask=0000000100",
                     release_error, allocated_ip_shared_ivc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (release_error !== 1'b1) begin
            errors++;
            $display("FAIL release_error_sticky: got %b, want 1", release_error);
        end
        do_reset();
        checks++;
        if (release_error !== 1'b0) begin
            errors++;
            $display("FAIL release_error_reset: got %b, want 0", release_error);
        end
    endtask

    task automatic test_back_to_back();
        logic g, n;
        logic [3:0] v;
        do_reset();
        set_own(5'b00001);
        do_req(g, n, v);
        do_req(g, n, v);
        checks++;
        if ({g, v, allocated_ip_shared_ivc} !== {1'b1, 4'd1, 10'b00000_00011}) begin
            errors++;
            $display("FAIL fill_bank0: got gnt=%b vc=%0d mask=%b, want gnt=1 vc=1 mask=0000000011",
                     g, v, allocated_ip_shared_ivc);
        end
        // Release of vc 0 lands on the same edge as the decision
        @(negedge clk);
        alloc_req = 1'b1;
        @(negedge clk);
        alloc_req = 1'b0;
        release_valid = 1'b1;
        release_vc = 4'd0;
        @(negedge clk);
        release_valid = 1'b0;
        checks++;
        if ({alloc_gnt, alloc_nack, allocated_ip_shared_ivc} !== {2'b01, 10'b00000_00010}) begin
            errors++;
            $display("FAIL same_cycle_release: got gnt=%b nack=%b mask=%b, want nack=1 mask=0000000010",
                     alloc_gnt, alloc_nack, allocated_ip_shared_ivc);
        end
        do_req(g, n, v);
        checks++;
        if ({g, v} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL realloc_vc0: got gnt=%b vc=%0d, want gnt=1 vc=0", g, v);
        end
    endtask

    task automatic test_ready_drop();
        do_reset();
        set_own(5'b00001);
        @(negedge clk);
        alloc_req = 1'b1;
        @(negedge clk);
        alloc_req = 1'b0;
        ready_for_allocation = 5'b00000;
        @(negedge clk);
        checks++;
        if ({alloc_gnt, alloc_nack} !== 2'b01) begin
            errors++;
            $display("FAIL ready_drop: got gnt=%b nack=%b, want nack", alloc_gnt, alloc_nack);
        end
        ready_for_allocation = 5'b11111;
    endtask

    initial begin
        reset = 1'b1;
        alloc_req = 1'b0;
        release_valid = 1'b0;
        release_vc = 4'd0;
        memory_bank_grant_in = 25'd0;
        ready_for_allocation = 5'b11111;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_draining();
        test_release_error();
        test_back_to_back();
        test_ready_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at 200000, want finished");
        $fatal(1, "timeout");
    end

endmodule
